// File: rtl/pwm_capture_if.sv
// Bundles the PWM capture input and its measurement outputs.
// master: the capture block; slave: the register block or control logic that consumes it.
interface pwm_capture_if #(
  parameter int unsigned WIDTH = 17
);
  logic             pwm_in;
  logic [WIDTH-1:0] high_time;
  logic [WIDTH-1:0] period;
  logic             valid;
  logic             stuck;
  logic             level;

  modport master (
    input  pwm_in,
    output high_time,
    output period,
    output valid,
    output stuck,
    output level
  );

  modport slave (
    output pwm_in,
    input  high_time,
    input  period,
    input  valid,
    input  stuck,
    input  level
  );
endinterface

// File: rtl/pwm_capture.sv
// PWM capture: measures high time and rise-to-rise period of an async input in clk cycles.
// Optional run-length glitch filter enabled by defining PWM_CAPTURE_FILTER_EN.
module pwm_capture #(
  parameter int unsigned WIDTH      = 17,
  parameter int unsigned FILTER_LEN = 3
) (
  input  logic           clk,
  input  logic           reset,
  pwm_capture_if.master  bus
);

  typedef enum logic [1:0] {StIdle, StHigh, StLow} state_e;

  // Last count value before the counter would reach all-ones.
  localparam logic [WIDTH-1:0] CntTimeout = {{(WIDTH-1){1'b1}}, 1'b0};
  localparam logic [WIDTH-1:0] CntOne     = {{(WIDTH-1){1'b0}}, 1'b1};

  logic sync1_q, sync2_q;
  logic lvl, lvl_prev_q;
  logic rise, fall;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      lvl_prev_q <= 1'b0;
    end else begin
      sync1_q    <= bus.pwm_in;
      sync2_q    <= sync1_q;
      lvl_prev_q <= lvl;
    end
  end

`ifdef PWM_CAPTURE_FILTER_EN
  logic       filt_level_q, filt_level_d;
  logic [3:0] run_q, run_d;

  // Flip only after FILTER_LEN consecutive samples disagree with the current level.
  always_comb begin
    filt_level_d = filt_level_q;
    run_d        = 4'd0;
    if (sync2_q != filt_level_q) begin
      if (run_q == 4'(FILTER_LEN - 1)) begin
        filt_level_d = sync2_q;
      end else begin
        run_d = run_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      filt_level_q <= 1'b0;
      run_q        <= 4'd0;
    end else begin
      filt_level_q <= filt_level_d;
      run_q        <= run_d;
    end
  end

  assign lvl = filt_level_q;
`else
  assign lvl = sync2_q;
`endif

  assign rise = lvl & ~lvl_prev_q;
  assign fall = ~lvl & lvl_prev_q;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic [WIDTH-1:0] high_q, high_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic             valid_q, valid_d;
  logic             stuck_q, stuck_d;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hold_d   = hold_q;
    high_d   = high_q;
    period_d = period_q;
    valid_d  = 1'b0;
    stuck_d  = stuck_q;
    case (state_q)
      StIdle: begin
        if (rise) begin
          cnt_d   = CntOne;
          state_d = StHigh;
        end
      end
      StHigh: begin
        if (fall) begin
          hold_d  = cnt_q;
          cnt_d   = cnt_q + CntOne;
          state_d = StLow;
        end else if (cnt_q == CntTimeout) begin
          stuck_d = 1'b1;
          cnt_d   = '0;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      StLow: begin
        if (rise) begin
          high_d   = hold_q;
          period_d = cnt_q;
          valid_d  = 1'b1;
          stuck_d  = 1'b0;
          cnt_d    = CntOne;
          state_d  = StHigh;
        end else if (cnt_q == CntTimeout) begin
          stuck_d = 1'b1;
          cnt_d   = '0;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      hold_q   <= '0;
      high_q   <= '0;
      period_q <= '0;
      valid_q  <= 1'b0;
      stuck_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hold_q   <= hold_d;
      high_q   <= high_d;
      period_q <= period_d;
      valid_q  <= valid_d;
      stuck_q  <= stuck_d;
    end
  end

  assign bus.high_time = high_q;
  assign bus.period    = period_q;
  assign bus.valid     = valid_q;
  assign bus.stuck     = stuck_q;
  assign bus.level     = lvl;

endmodule

// File: tb/tb_pwm_capture.sv
// Scoreboard bench for pwm_capture at reduced WIDTH so timeouts fit a short run.
// Expected (high, period) pairs are queued at each driven rise and popped on valid.
module tb_pwm_capture;
  localparam int unsigned W       = 10;
  localparam int          Ones    = (1 << W) - 1;
  localparam int unsigned FiltLen = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pwm_capture_if #(.WIDTH(W)) bus_if ();

  pwm_capture #(
    .WIDTH      (W),
    .FILTER_LEN (FiltLen)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  typedef struct {
    int h;
    int p;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   prev_h   = 0;
  int   prev_p   = 0;
  bit   meas     = 1'b0;
  int   last_h   = 0;
  int   last_p   = 0;
  logic valid_prev;

  task automatic check_val(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Model: a rise completes the previous period if the block was measuring.
  task automatic start_period(input int h, input int p);
    if (meas) exp_q.push_back('{h: prev_h, p: prev_p});
    prev_h = h;
    prev_p = p;
    meas   = (h <= Ones - 1) && (p <= Ones - 1);
  endtask

  task automatic drive_level(input logic v, input int n);
    bus_if.pwm_in = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_period(input int h, input int p);
    start_period(h, p);
    drive_level(1'b1, h);
    drive_level(1'b0, p - h);
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_high_time"}, int'(bus_if.high_time), 0);
    check_val({tag, "_period"}, int'(bus_if.period), 0);
    check_val({tag, "_valid"}, int'(bus_if.valid), 0);
    check_val({tag, "_stuck"}, int'(bus_if.stuck), 0);
    check_val({tag, "_level"}, int'(bus_if.level), 0);
  endtask

  always @(negedge clk) begin
    if (reset) begin
      valid_prev <= 1'b0;
    end else begin
      if (bus_if.valid) begin
        check_val("valid_pulse", int'(valid_prev), 0);
        check_val("valid_expected", int'(exp_q.size() > 0), 1);
        check_val("stuck_on_valid", int'(bus_if.stuck), 0);
        if (exp_q.size() > 0) begin
          check_val("high_time", int'(bus_if.high_time), exp_q[0].h);
          check_val("period", int'(bus_if.period), exp_q[0].p);
          last_h <= exp_q[0].h;
          last_p <= exp_q[0].p;
          exp_q.delete(0);
        end
      end
      valid_prev <= bus_if.valid;
    end
  end

  initial begin
    reset         = 1'b1;
    bus_if.pwm_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("in_reset");
    reset = 1'b0;
    @(negedge clk);
    check_all_zero("after_reset");
    @(posedge clk);
    #1;

    // Steady 10/30 waveform.
    repeat (5) drive_period(10, 40);

    // Generator-like long periods up to the largest reportable one.
    drive_period(257, Ones - 1);
    drive_period(257, Ones - 1);
`ifdef PWM_CAPTURE_FILTER_EN
    drive_period(FiltLen, Ones - 1);
    drive_period(FiltLen, Ones - 1);
`else
    drive_period(1, Ones - 1);
    drive_period(1, Ones - 1);
    drive_period(39, 40);
`endif
    drive_period(10, 40);

    // A period of all-ones cycles times out in LOW and is not reported.
    drive_period(10, Ones);
    repeat (3) drive_period(10, 40);

    // Stuck high: stuck exactly Ones cycles after the rise detect.
    start_period(Ones + 1, Ones + 1);
    bus_if.pwm_in = 1'b1;
    begin
      int n = 0;
      while (n < 20 && bus_if.level !== 1'b1) begin
        @(negedge clk);
        n++;
      end
      check_val("level_rise_seen", int'(bus_if.level), 1);
    end
    repeat (Ones - 1) @(negedge clk);
    check_val("stuck_early", int'(bus_if.stuck), 0);
    @(negedge clk);
    check_val("stuck_set", int'(bus_if.stuck), 1);
    check_val("stuck_keep_high_time", int'(bus_if.high_time), last_h);
    check_val("stuck_keep_period", int'(bus_if.period), last_p);
    @(posedge clk);
    #1;
    drive_level(1'b1, 5);
    drive_level(1'b0, 30);
    drive_period(10, 40);
    check_val("stuck_held", int'(bus_if.stuck), 1);
    repeat (3) drive_period(10, 40);

    // Reset in the middle of a high phase.
    start_period(10, 40);
    drive_level(1'b1, 12);
    reset         = 1'b1;
    bus_if.pwm_in = 1'b0;
    meas          = 1'b0;
    #1;
    check_all_zero("mid_reset");
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    drive_level(1'b0, 20);
    repeat (3) drive_period(10, 40);

    // One-cycle high glitch inside the low phase.
`ifdef PWM_CAPTURE_FILTER_EN
    start_period(10, 40);
    drive_level(1'b1, 10);
    drive_level(1'b0, 15);
    drive_level(1'b1, 1);
    drive_level(1'b0, 14);
`else
    drive_period(10, 25);
    drive_period(1, 15);
`endif
    repeat (2) drive_period(10, 40);

    // Final rise completes the last driven period.
    start_period(10, 40);
    drive_level(1'b1, 10);
    drive_level(1'b0, 30);
    repeat (10) @(negedge clk);
    check_val("sb_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pwm_capture.md
Name: pwm_capture

Overview:
- Measures an incoming PWM waveform; the inverse of the team's 16-bit PWM generator.
- Samples an asynchronous input and counts clk cycles of high time and full period (rising edge to rising edge).
- Publishes both counts with a one-cycle valid strobe, and flags a stuck or absent input.
- Sits behind an I2C register block or drives control logic directly.
- Default width measures the generator's full 65537-cycle period without saturating.

Parameters:
- WIDTH, 17, width of the counters and of the high_time/period outputs.
- FILTER_LEN, 3, consecutive equal samples needed to accept a level change. Used only with PWM_CAPTURE_FILTER_EN; legal range 2..15.

Ports:
- clk  input  1  system clock.
- reset  input  1  reset; asynchronous, active-high.
- pwm_in  input  1  asynchronous PWM input.
- high_time  output  WIDTH  last complete high duration, in clk cycles.
- period  output  WIDTH  last complete period, in clk cycles.
- valid  output  1  one-cycle pulse when high_time/period update.
- stuck  output  1  input has had no edge within the counter range.
- level  output  1  synchronized (filtered) input level.

Behaviour:
- Reset (async, active-high) forces these values: sync flops 0, level 0, state IDLE, cnt 0, high_time 0, period 0, valid 0, stuck 0. Asserting reset mid-measurement discards the partial measurement.
- Input path: 2-flop synchronizer, then a level register. rise = level goes 0→1; fall = level goes 1→0. The level register updates on the 2nd clk edge after a pwm_in change is sampled, so an input transition is internal 2 cycles later. Both edges see the same delay, so measured widths are exact.
- States:
  - IDLE: waiting for the first rise.
  - HIGH: counting the high phase.
  - LOW: counting the low phase.
- IDLE:
  - A fall in IDLE is ignored.
  - On rise: cnt<=1, go to HIGH, no valid.
- HIGH:
  - cnt increments each cycle.
  - On fall: hold_high<=cnt, go to LOW.
- LOW:
  - cnt increments each cycle.
  - On rise: high_time<=hold_high, period<=cnt, valid<=1 for one cycle, stuck<=0, cnt<=1, go to HIGH.
- Count semantics: cnt equals k exactly k cycles after the rise-detect cycle. A steady input of H high and P total cycles therefore yields high_time=H and period=P.
- valid is asserted in the cycle after the completing rise is detected. The outputs carry the new values in that same cycle and hold them until the next update.
- Timeout: if cnt reaches all-ones in HIGH or LOW without an edge:
  - stuck<=1, state<=IDLE, cnt<=0.
  - No valid pulse; high_time/period keep their previous values.
  - stuck stays 1 until the next valid.
- Timeout rule: a period of 2^WIDTH-1 cycles or more is never reported.
- Minimum measurable pulse: 1 cycle high or 1 cycle low. A pulse shorter than one clk may be missed; a missed pulse merges two periods, with no error flag.
- The first rise after reset or timeout only arms the block; the first valid needs a full period after it.

Optional Feature:
- Macro: PWM_CAPTURE_FILTER_EN.
- Defined:
  - A run-length filter sits between the synchronizer and level.
  - level changes only after FILTER_LEN consecutive samples differ from the current level.
  - Both edges are delayed by FILTER_LEN extra cycles, so widths of pulses ≥ FILTER_LEN cycles are unchanged.
  - Shorter pulses are suppressed entirely and absorbed into the surrounding phase.
- Undefined: no filter; level is the 2nd synchronizer output and every 1-cycle pulse is measured.

Test Plan:
- Reset values: assert reset, then release. Required: high_time=0, period=0, valid=0, stuck=0, level=0. No valid until 2 full periods of input.
- Steady waveform: pwm_in 10 cycles high / 30 low, repeating. Required: valid once per 40 cycles, high_time=10, period=40, from the 2nd rising edge on.
- Drive from the PWM generator (duty_cycle=16'h0100): required high_time=17'h00101, period=17'h10001. Repeat with duty 0: required high_time=1, period=17'h10001.
- Stuck input:
  - Hold pwm_in=1 after a rise. Required: stuck=1 exactly 2^17-1 cycles after the rise detect, no valid, prior outputs retained.
  - Then restore the 10/30 waveform. Required: stuck clears on the 1st new valid.
- Reset mid-measurement: assert reset mid-HIGH. Required: all outputs 0, IDLE; the next rise produces no valid.
- Glitch:
  - A 1-cycle high glitch in the low phase of 10/30, without PWM_CAPTURE_FILTER_EN. Required: the glitch is measured as a short period.
  - Same glitch with PWM_CAPTURE_FILTER_EN, FILTER_LEN=3. Required: glitch ignored, high_time=10, period=40.
